// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   APB requester: turns single-beat commands from a local valid/ready port
//   into APB SETUP/ACCESS transfers and reports each completion on a
//   one-cycle response pulse carrying read data and error/timeout status.
//
// Ports
//   PCLK, PRESET              clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake; accepted when both are high
//   cmd_write/addr/wdata      command direction, address, write data
//   rsp_valid                 one-cycle completion pulse
//   rsp_rdata/err/timeout     completion data/status, held until next pulse
//   busy                      a transfer is in flight
//   PSEL..PWDATA              APB requester outputs
//   PRDATA, PREADY, PSLVERR   APB completer inputs
module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    localparam bit              TO_EN   = (TIMEOUT != 0);
    // Last ACCESS wait cycle before the transfer is abandoned.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [TO_W-1:0]   wait_q, wait_d;

    logic              psel_d, penable_d, pwrite_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d;
    logic              rsp_valid_d, rsp_err_d, rsp_timeout_d;
    logic [DATA_W-1:0] rsp_rdata_d;

    assign cmd_ready = (state_q == IDLE) && !PRESET;

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        psel_d        = PSEL;
        penable_d     = PENABLE;
        pwrite_d      = PWRITE;
        paddr_d       = PADDR;
        pwdata_d      = PWDATA;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;
        rsp_rdata_d   = rsp_rdata;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                wait_d    = '0;
            end
            ACCESS: begin
                // PREADY is checked first so a completer answering on the
                // last allowed cycle still wins over the timeout.
                if (PREADY) begin
                    state_d       = IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = PWRITE ? '0 : PRDATA;
                end else if (TO_EN && (wait_q == TO_LAST)) begin
                    state_d       = IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            busy        <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            busy        <= (state_d != IDLE);
            PSEL        <= psel_d;
            PENABLE     <= penable_d;
            PWRITE      <= pwrite_d;
            PADDR       <= paddr_d;
            PWDATA      <= pwdata_d;
            rsp_valid   <= rsp_valid_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
            rsp_rdata   <= rsp_rdata_d;
        end
    end

endmodule
